change_dispenser: RTL and testbench

Downstream stage of the vending controller. Consumes the controller's CAN flag and 6-bit CHG value (cents). On each new vend it fires one can-release pulse, then returns change as a greedy sequence of quarter, dime and nickel eject pulses. It reports completion so the system can reset the controller for the next customer.

---
 rtl/change_dispenser.sv | 148 ++++++++++++++
 tb/tb_change_dispenser.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: fires one can-release pulse per vend, then ejects
// greedy quarter/dime/nickel change and signals completion.
module change_dispenser #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       CAN,
    input  logic [5:0] CHG,
    output logic       DISP_CAN,
    output logic       EJ_Q,
    output logic       EJ_D,
    output logic       EJ_N,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [2:0] COINS
);

    typedef enum logic [2:0] {
        S_IDLE, S_VEND, S_GAP, S_SEL,
        S_EJECT, S_DONE, S_WAIT_LOW, S_ERR
    } state_t;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYCLES - 1);

    state_t     state_q;
    logic       can_q;
    logic [3:0] cnt_q;
    logic [5:0] remain_q;
    logic [2:0] coins_q;
    logic       disp_q, ejq_q, ejd_q, ejn_q;
    logic       busy_q, done_q, err_q;

    logic       bad_chg_d;
    logic       trig_d;
    logic       ejq_d, ejd_d, ejn_d;
    logic [5:0] remain_d;

    always_comb begin
        bad_chg_d = (CHG > 6'd45) || ((CHG % 6'd5) != 6'd0);
        trig_d    = CAN && !can_q;
        ejq_d     = 1'b0;
        ejd_d     = 1'b0;
        ejn_d     = 1'b0;
        remain_d  = remain_q;
        // Greedy pick of the next coin from what is still owed.
        if (remain_q >= 6'd25) begin
            ejq_d    = 1'b1;
            remain_d = remain_q - 6'd25;
        end else if (remain_q >= 6'd10) begin
            ejd_d    = 1'b1;
            remain_d = remain_q - 6'd10;
        end else if (remain_q >= 6'd5) begin
            ejn_d    = 1'b1;
            remain_d = remain_q - 6'd5;
        end
    end

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            can_q    <= 1'b1;
            cnt_q    <= 4'd0;
            remain_q <= 6'd0;
            coins_q  <= 3'd0;
            disp_q   <= 1'b0;
            ejq_q    <= 1'b0;
            ejd_q    <= 1'b0;
            ejn_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            can_q <= CAN;
            unique case (state_q)
                S_IDLE: begin
                    if (trig_d) begin
                        remain_q <= CHG;
                        coins_q  <= 3'd0;
                        if (bad_chg_d) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_VEND;
                            busy_q  <= 1'b1;
                            disp_q  <= 1'b1;
                            cnt_q   <= PULSE_LD;
                        end
                    end
                end
                S_VEND, S_EJECT: begin
                    if (cnt_q == 4'd0) begin
                        disp_q  <= 1'b0;
                        ejq_q   <= 1'b0;
                        ejd_q   <= 1'b0;
                        ejn_q   <= 1'b0;
                        cnt_q   <= GAP_LD;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_GAP, S_SEL: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (remain_q == 6'd0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= S_EJECT;
                        ejq_q    <= ejq_d;
                        ejd_q    <= ejd_d;
                        ejn_q    <= ejn_d;
                        remain_q <= remain_d;
                        cnt_q    <= PULSE_LD;
                        if (coins_q != 3'd7) coins_q <= coins_q + 3'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!CAN) state_q <= S_IDLE;
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign DISP_CAN = disp_q;
    assign EJ_Q     = ejq_q;
    assign EJ_D     = ejd_q;
    assign EJ_N     = ejn_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign COINS    = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed vector bench for change_dispenser: per-cycle waveform
// checks of vend/eject sequences plus error and reset corner cases.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 2;
    localparam int T = P + G;

    logic       Clk = 1'b0;
    logic       RST;
    logic       CAN;
    logic [5:0] CHG;
    logic       DISP_CAN, EJ_Q, EJ_D, EJ_N, BUSY, DONE, ERR;
    logic [2:0] COINS;

    int errs   = 0;
    int checks = 0;

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .Clk(Clk), .RST(RST), .CAN(CAN), .CHG(CHG),
        .DISP_CAN(DISP_CAN), .EJ_Q(EJ_Q), .EJ_D(EJ_D), .EJ_N(EJ_N),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .COINS(COINS)
    );

    always #5 Clk = ~Clk;

    // Codes: 1 = quarter, 2 = dime, 3 = nickel, 0 = unused slot.
    typedef struct {
        logic [5:0] chg;
        logic [1:0] c [3];
        int         k;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [6:0] obs();
        return {DISP_CAN, EJ_Q, EJ_D, EJ_N, BUSY, DONE, ERR};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic [6:0] e;
        int         ec;
        int         s;
        @(negedge Clk);
        CAN = 1'b0;
        CHG = v.chg;
        @(negedge Clk);
        @(negedge Clk);
        CAN = 1'b1;
        for (int n = 0; n <= (v.k + 1) * T + 2; n++) begin
            @(negedge Clk);
            e  = '0;
            ec = 0;
            e[6] = (n < P);
            for (int i = 0; i < v.k; i++) begin
                s = (i + 1) * T;
                if (n >= s) ec++;
                if (n >= s && n < s + P) begin
                    e[5] = (v.c[i] == 2'd1);
                    e[4] = (v.c[i] == 2'd2);
                    e[3] = (v.c[i] == 2'd3);
                end
            end
            e[2] = (n <= (v.k + 1) * T);
            e[1] = (n == (v.k + 1) * T);
            chk($sformatf("chg%0d_out_c%0d", v.chg, n),
                32'(obs()), 32'(e));
            chk($sformatf("chg%0d_coins_c%0d", v.chg, n),
                32'(COINS), 32'(ec));
            if (n == 10) CHG = 6'd5;
        end
    endtask

    task automatic hold(input int ncyc, input int k);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge Clk);
            chk($sformatf("hold_out_c%0d", n), 32'(obs()), 32'd0);
            chk($sformatf("hold_coins_c%0d", n), 32'(COINS), 32'(k));
        end
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        RST = 1'b1;
        #1;
        chk("rst_out", 32'(obs()), 32'd0);
        chk("rst_coins", 32'(COINS), 32'd0);
        @(negedge Clk);
        RST = 1'b0;
    endtask

    task automatic err_txn(input logic [5:0] chg);
        @(negedge Clk);
        CAN = 1'b0;
        CHG = chg;
        @(negedge Clk);
        @(negedge Clk);
        CAN = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge Clk);
            if (n == 0)
                chk($sformatf("err%0d_act_c0", chg),
                    32'(obs() >> 3), 32'd0);
            else
                chk($sformatf("err%0d_out_c%0d", chg, n),
                    32'(obs()), 32'b0000001);
            if (n == 3) CAN = 1'b0;
            if (n == 5) CAN = 1'b1;
            if (n == 8) CAN = 1'b0;
        end
    endtask

    initial begin
        tbl[0] = '{chg: 6'd0,  c: '{2'd0, 2'd0, 2'd0}, k: 0};
        tbl[1] = '{chg: 6'd15, c: '{2'd2, 2'd3, 2'd0}, k: 2};
        tbl[2] = '{chg: 6'd45, c: '{2'd1, 2'd2, 2'd2}, k: 3};
        tbl[3] = '{chg: 6'd5,  c: '{2'd3, 2'd0, 2'd0}, k: 1};
        tbl[4] = '{chg: 6'd25, c: '{2'd1, 2'd0, 2'd0}, k: 1};
        tbl[5] = '{chg: 6'd40, c: '{2'd1, 2'd2, 2'd3}, k: 3};
        tbl[6] = '{chg: 6'd30, c: '{2'd1, 2'd3, 2'd0}, k: 2};

        RST = 1'b1;
        CAN = 1'b1;
        CHG = 6'd0;
        repeat (2) @(negedge Clk);
        chk("reset_out", 32'(obs()), 32'd0);
        chk("reset_coins", 32'(COINS), 32'd0);
        RST = 1'b0;
        // CAN held high through reset must not start a vend.
        for (int n = 0; n < 4; n++) begin
            @(negedge Clk);
            chk($sformatf("post_rst_can_hi_c%0d", n), 32'(obs()), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i]);
            hold((i == 2) ? 10 : 2, tbl[i].k);
        end

        err_txn(6'd50);
        pulse_reset();
        err_txn(6'd7);
        pulse_reset();

        // Reset in the middle of a quarter pulse.
        @(negedge Clk);
        CAN = 1'b0;
        CHG = 6'd25;
        @(negedge Clk);
        @(negedge Clk);
        CAN = 1'b1;
        for (int n = 0; n <= 7; n++) @(negedge Clk);
        chk("mid_ejq_before_rst", 32'(obs()), 32'b0100100);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_out", 32'(obs()), 32'd0);
        chk("mid_rst_coins", 32'(COINS), 32'd0);
        @(negedge Clk);
        RST = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge Clk);
            chk($sformatf("mid_rst_can_hi_c%0d", n), 32'(obs()), 32'd0);
        end
        run_txn(tbl[3]);
        hold(2, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
